// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS-style pipeline slice.
//   - ALU opcode constants used by decode, ID/EX and the ALU.
//   - REG_ZERO: index of the hard-wired zero register, which is never
//     a forwarding source and never causes a load-use stall.
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_SLT  = 3'd6;
  localparam logic [2:0] ALU_ADDI = 3'd7;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every non-clock/reset signal of the ID/EX pipeline register.
//   master : the surrounding pipeline (decode, hazard consumers, EX/MEM and
//            MEM/WB forward sources); drives id_*, flush, hold, exmem_*,
//            memwb_*; observes stall_out and the ALU/EX outputs.
//   slave  : the id_ex_stage itself.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Decode side
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [2:0]        id_alu_op;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  // Pipeline control
  logic              flush;
  logic              hold;
  // Forward sources
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  // Outputs
  logic              stall_out;
  logic [2:0]        aluOp;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_store_data;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           flush, hold,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  stall_out, aluOp, op1, op2, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd, ex_store_data
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           flush, hold,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output stall_out, aluOp, op1, op2, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Selects the most recent value of one source register for the EX stage.
//   index_i            : registered source-register index
//   reg_data_i         : registered register-file read data
//   exmem_*_i          : newer forward source (wins on double hit)
//   memwb_*_i          : older forward source
//   data_o             : selected operand
// Purely combinational. Register zero never matches a forward source.
// ---------------------------------------------------------------------------
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] index_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] data_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != REG_AW'(REG_ZERO))
                     && (exmem_rd_i == index_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != REG_AW'(REG_ZERO))
                     && (memwb_rd_i == index_i);

  always_comb begin
    data_o = reg_data_i;
    if (exmem_hit) begin
      data_o = exmem_result_i;
    end else if (memwb_hit) begin
      data_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the ALU, with result forwarding and
// load-use hazard detection.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : id_ex_stage_if slave modport (decode inputs, flush/hold,
//              EX/MEM and MEM/WB forward sources, stall_out, ALU operands
//              and registered EX control)
// Edge priority: rst > flush > hold > load-use bubble > capture.
// ---------------------------------------------------------------------------
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [2:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_regs_t;

  // A bubble is an all-zero slot: invalid, no side effects, aluOp = add.
  localparam ex_regs_t BUBBLE = '0;

  ex_regs_t ex_q;
  ex_regs_t ex_d;

  logic              stall;
  logic              rs_dep;
  logic              rt_dep;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load-use: the load in EX cannot forward its data in time. rt only
  // counts when the decoded instruction actually reads it as a register
  // (R-type, or a store whose rt is the store data).
  assign rs_dep = (ex_q.rd == bus.id_rs);
  assign rt_dep = (ex_q.rd == bus.id_rt) && (!bus.id_alu_src || bus.id_mem_write);
  assign stall  = bus.id_valid && ex_q.valid && ex_q.mem_read
                  && (ex_q.rd != REG_AW'(REG_ZERO)) && (rs_dep || rt_dep);

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = BUBBLE;
    end else if (bus.hold) begin
      ex_d = ex_q;
    end else if (stall) begin
      ex_d = BUBBLE;
    end else begin
      ex_d.valid     = bus.id_valid;
      ex_d.rs        = bus.id_rs;
      ex_d.rt        = bus.id_rt;
      ex_d.rd        = bus.id_rd;
      ex_d.rs_data   = bus.id_rs_data;
      ex_d.rt_data   = bus.id_rt_data;
      ex_d.imm       = bus.id_imm;
      ex_d.alu_op    = bus.id_alu_op;
      ex_d.alu_src   = bus.id_alu_src;
      ex_d.reg_write = bus.id_reg_write && bus.id_valid;
      ex_d.mem_read  = bus.id_mem_read  && bus.id_valid;
      ex_d.mem_write = bus.id_mem_write && bus.id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .index_i           (ex_q.rs),
    .reg_data_i        (ex_q.rs_data),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_result_i    (bus.memwb_result),
    .data_o            (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .index_i           (ex_q.rt),
    .reg_data_i        (ex_q.rt_data),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_result_i    (bus.memwb_result),
    .data_o            (fwd_rt)
  );

  assign bus.stall_out     = stall;
  assign bus.aluOp         = ex_q.alu_op;
  assign bus.op1           = fwd_rs;
  assign bus.op2           = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [2:0]  op;
    logic        src, rw, mr, mw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] e_op1, e_op2, e_store;
    logic        e_valid, e_rw, e_mw;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_alu_op = 0; bus.id_alu_src = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.flush = 0; bus.hold = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_data, input logic [31:0] rt_data,
                          input logic [31:0] imm, input logic [2:0] op, input logic src,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rs_data; bus.id_rt_data = rt_data; bus.id_imm = imm;
    bus.id_alu_op = op; bus.id_alu_src = src; bus.id_reg_write = rw;
    bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rs_data, input logic [31:0] rt_data, input logic [31:0] imm,
    input logic [2:0] op, input logic src, input logic rw, input logic mw,
    input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
    input logic ww, input logic [4:0] wrd, input logic [31:0] wres,
    input logic [31:0] e_op1, input logic [31:0] e_op2, input logic [31:0] e_store,
    input logic e_valid, input logic e_rw, input logic e_mw);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rs_data = rs_data; v.rt_data = rt_data; v.imm = imm;
    v.op = op; v.src = src; v.rw = rw; v.mr = 1'b0; v.mw = mw;
    v.xw = xw; v.xrd = xrd; v.xres = xres;
    v.ww = ww; v.wrd = wrd; v.wres = wres;
    v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_store = e_store;
    v.e_valid = e_valid; v.e_rw = e_rw; v.e_mw = e_mw; v.e_rd = rd;
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //           vld rs  rt  rd  rs_data       rt_data  imm  op        src rw mw  xw xrd xres      ww wrd wres      op1           op2   store  ev erw emw
    vecs[0] = mk(1, 1,  2,  5,  32'h5,        32'h7,   0,   ALU_ADD,  0,  1, 0,  0, 0,  0,        0, 0,  0,        32'h5,        32'h7, 32'h7, 1, 1, 0);
    vecs[1] = mk(1, 3,  6,  7,  32'h11,       32'h22,  0,   ALU_SUB,  0,  1, 0,  1, 3,  32'hAA,   1, 3,  32'hBB,   32'hAA,       32'h22,32'h22,1, 1, 0);
    vecs[2] = mk(1, 3,  6,  7,  32'h11,       32'h22,  0,   ALU_SUB,  0,  1, 0,  0, 3,  32'hAA,   1, 3,  32'hBB,   32'hBB,       32'h22,32'h22,1, 1, 0);
    vecs[3] = mk(1, 0,  0,  8,  32'h0,        32'h0,   0,   ALU_OR,   0,  1, 0,  1, 0,  32'hDEAD, 1, 0,  32'hBEEF, 32'h0,        32'h0, 32'h0, 1, 1, 0);
    vecs[4] = mk(1, 1,  2,  0,  32'h100,      32'h1,   8,   ALU_ADDI, 1,  0, 1,  1, 2,  32'h55,   0, 0,  0,        32'h100,      32'h8, 32'h55,1, 0, 1);
    vecs[5] = mk(1, 9,  10, 11, 32'h3,        32'h4,   0,   ALU_AND,  0,  1, 0,  1, 11, 32'h99,   1, 10, 32'h77,   32'h3,        32'h77,32'h77,1, 1, 0);
    vecs[6] = mk(0, 1,  2,  9,  32'h12,       32'h34,  0,   ALU_XOR,  0,  1, 1,  0, 0,  0,        0, 0,  0,        32'h12,       32'h34,32'h34,0, 0, 0);
    vecs[7] = mk(1, 12, 13, 14, 32'h80000000, 32'h1,   0,   ALU_SLT,  0,  1, 0,  0, 12, 32'h5,    0, 13, 32'h6,    32'h80000000, 32'h1, 32'h1, 1, 1, 0);

    // Reset: a valid instruction on id_* must not be captured.
    clear_inputs();
    rst = 1;
    drive_id(1, 2, 5, 32'h5, 32'h7, 0, ALU_SUB, 0, 1, 0, 0);
    next_cycle();
    next_cycle();
    chk("rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("rst_ex_reg_write", 32'(bus.ex_reg_write), 0);
    chk("rst_ex_mem_read", 32'(bus.ex_mem_read), 0);
    chk("rst_ex_mem_write", 32'(bus.ex_mem_write), 0);
    chk("rst_ex_rd", 32'(bus.ex_rd), 0);
    chk("rst_aluOp", 32'(bus.aluOp), 0);
    chk("rst_op1", bus.op1, 0);
    chk("rst_op2", bus.op2, 0);
    chk("rst_store", bus.ex_store_data, 0);
    chk("rst_stall", 32'(bus.stall_out), 0);
    rst = 0;
    clear_inputs();

    // Table-driven captures with forwarding.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      clear_inputs();
      drive_id(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_data, vecs[i].rt_data,
               vecs[i].imm, vecs[i].op, vecs[i].src, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      bus.id_valid = vecs[i].valid;
      bus.exmem_reg_write = vecs[i].xw; bus.exmem_rd = vecs[i].xrd; bus.exmem_result = vecs[i].xres;
      bus.memwb_reg_write = vecs[i].ww; bus.memwb_rd = vecs[i].wrd; bus.memwb_result = vecs[i].wres;
      next_cycle();
      chk($sformatf("v%0d_op1", i), bus.op1, vecs[i].e_op1);
      chk($sformatf("v%0d_op2", i), bus.op2, vecs[i].e_op2);
      chk($sformatf("v%0d_store", i), bus.ex_store_data, vecs[i].e_store);
      chk($sformatf("v%0d_aluOp", i), 32'(bus.aluOp), 32'(vecs[i].op));
      chk($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_ex_reg_write", i), 32'(bus.ex_reg_write), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_ex_mem_write", i), 32'(bus.ex_mem_write), 32'(vecs[i].e_mw));
      chk($sformatf("v%0d_ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].e_rd));
      $display("[TB] vector %0d: op1=0x%08h op2=0x%08h store=0x%08h", i, bus.op1, bus.op2, bus.ex_store_data);
    end

    // Load-use: lw r4 in EX, dependent add in ID.
    next_cycle();
    clear_inputs();
    drive_id(1, 4, 4, 0, 0, 0, ALU_ADDI, 1, 1, 1, 0);
    next_cycle();
    clear_inputs();
    drive_id(7, 4, 9, 0, 0, 4, ALU_ADDI, 1, 1, 0, 0);
    #1 chk("lu_addi_rt_nostall", 32'(bus.stall_out), 0);
    drive_id(7, 4, 0, 0, 0, 4, ALU_ADDI, 1, 0, 0, 1);
    #1 chk("lu_sw_rt_stall", 32'(bus.stall_out), 1);
    drive_id(4, 2, 6, 32'hDEAD, 32'h3, 0, ALU_ADD, 0, 1, 0, 0);
    #1 chk("lu_add_rs_stall", 32'(bus.stall_out), 1);
    next_cycle();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
    chk("lu_bubble_reg_write", 32'(bus.ex_reg_write), 0);
    chk("lu_bubble_mem_read", 32'(bus.ex_mem_read), 0);
    chk("lu_stall_released", 32'(bus.stall_out), 0);
    bus.memwb_reg_write = 1; bus.memwb_rd = 4; bus.memwb_result = 32'h40;
    next_cycle();
    chk("lu_capture_valid", 32'(bus.ex_valid), 1);
    chk("lu_capture_op1", bus.op1, 32'h40);
    chk("lu_capture_op2", bus.op2, 32'h3);
    chk("lu_capture_rd", 32'(bus.ex_rd), 6);
    $display("[TB] load-use: op1=0x%08h op2=0x%08h", bus.op1, bus.op2);

    // Flush together with stall_out: flush wins, stall still reported.
    clear_inputs();
    drive_id(1, 4, 4, 0, 0, 0, ALU_ADDI, 1, 1, 1, 0);
    next_cycle();
    clear_inputs();
    drive_id(4, 2, 6, 0, 3, 0, ALU_ADD, 0, 1, 0, 0);
    bus.flush = 1;
    #1 chk("flush_stall_out", 32'(bus.stall_out), 1);
    next_cycle();
    chk("flush_stall_valid", 32'(bus.ex_valid), 0);
    chk("flush_stall_mem_read", 32'(bus.ex_mem_read), 0);
    $display("[TB] flush+stall: ex_valid=%0d", bus.ex_valid);

    // Reset mid-stall.
    clear_inputs();
    drive_id(1, 4, 4, 0, 0, 0, ALU_ADDI, 1, 1, 1, 0);
    next_cycle();
    clear_inputs();
    drive_id(4, 2, 6, 0, 3, 0, ALU_ADD, 0, 1, 0, 0);
    #1 chk("rststall_pre_stall", 32'(bus.stall_out), 1);
    rst = 1;
    next_cycle();
    rst = 0;
    chk("rststall_valid", 32'(bus.ex_valid), 0);
    chk("rststall_stall", 32'(bus.stall_out), 0);
    $display("[TB] reset mid-stall: ex_valid=%0d stall=%0d", bus.ex_valid, bus.stall_out);

    // Flush + hold: flush wins.
    clear_inputs();
    drive_id(1, 2, 7, 32'h10, 0, 0, ALU_ADD, 0, 1, 0, 0);
    next_cycle();
    chk("fh_pre_valid", 32'(bus.ex_valid), 1);
    bus.flush = 1; bus.hold = 1;
    next_cycle();
    chk("fh_valid", 32'(bus.ex_valid), 0);
    chk("fh_reg_write", 32'(bus.ex_reg_write), 0);
    $display("[TB] flush+hold: ex_valid=%0d", bus.ex_valid);

    // Hold alone keeps the slot for three cycles.
    clear_inputs();
    drive_id(1, 2, 8, 32'h21, 32'h22, 0, ALU_XOR, 0, 1, 0, 0);
    next_cycle();
    bus.hold = 1;
    drive_id(3, 5, 9, 32'h99, 32'h98, 0, ALU_OR, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk($sformatf("hold%0d_valid", c), 32'(bus.ex_valid), 1);
      chk($sformatf("hold%0d_rd", c), 32'(bus.ex_rd), 8);
      chk($sformatf("hold%0d_aluOp", c), 32'(bus.aluOp), 32'(ALU_XOR));
      chk($sformatf("hold%0d_op1", c), bus.op1, 32'h21);
      chk($sformatf("hold%0d_op2", c), bus.op2, 32'h22);
      chk($sformatf("hold%0d_reg_write", c), 32'(bus.ex_reg_write), 1);
      chk($sformatf("hold%0d_mem_write", c), 32'(bus.ex_mem_write), 0);
      $display("[TB] hold cycle %0d: ex_rd=%0d op1=0x%08h", c, bus.ex_rd, bus.op1);
    end
    bus.hold = 0;
    next_cycle();
    chk("hold_release_rd", 32'(bus.ex_rd), 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register that feeds the ALU. It captures decoded operands and control from the ID stage and applies EX/MEM and MEM/WB result forwarding to produce the ALU's `aluOp`, `op1` and `op2`. It also detects load-use hazards and holds fetch/decode while inserting a bubble. It sits between the register-file read and the ALU, one clock of latency.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_AW`, 5, register-index width

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: decode slot holds a real instruction
- `id_rs`, `id_rt`, `id_rd` in REG_AW: source/dest indices (`id_rd` already muxed rt/rd by decode)
- `id_rs_data`, `id_rt_data` in DATA_W: register-file read data
- `id_imm` in DATA_W: extended immediate
- `id_alu_op` in 3: ALU opcode (0 add … 7 add)
- `id_alu_src` in 1: 1 = op2 takes immediate
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits
- `flush` in 1: squash the instruction being captured (taken branch)
- `hold` in 1: downstream stall, freeze ID/EX
- `exmem_reg_write` in 1, `exmem_rd` in REG_AW, `exmem_result` in DATA_W: EX/MEM forward source
- `memwb_reg_write` in 1, `memwb_rd` in REG_AW, `memwb_result` in DATA_W: MEM/WB forward source
- `stall_out` out 1: hold PC and IF/ID this cycle
- `aluOp` out 3, `op1` out DATA_W, `op2` out DATA_W: to ALU
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control
- `ex_rd` out REG_AW, `ex_store_data` out DATA_W: to EX/MEM

## Operation
- Registered fields: valid, rs, rt, rd, rs_data, rt_data, imm, alu_op, alu_src, reg_write, mem_read, mem_write.
- Per-edge priority: `rst` > `flush` > `hold` > load-use bubble > normal capture.
  - `rst`/`flush`: all registered fields to 0 (bubble: valid=0, all write/read enables 0).
  - `hold`: all fields keep their value; `stall_out` still computed.
  - bubble: same as flush, taken when `stall_out`=1 and `hold`=0.
  - capture: all fields load from `id_*`; control bits ANDed with `id_valid`.
- Load-use hazard: `stall_out` = `id_valid` & `ex_valid` & `ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs` | (`ex_rd`==`id_rt` & (!`id_alu_src` | `id_mem_write`))). Purely combinational.
- Forwarding, per source operand (rs, then rt), combinational from registered index/data:
  - EX/MEM hit: `exmem_reg_write` & `exmem_rd`≠0 & `exmem_rd`==index → `exmem_result`.
  - else MEM/WB hit, same rule → `memwb_result`.
  - else registered register-file data. EX/MEM wins when both match.
- `op1` = forwarded rs; `op2` = registered imm if alu_src else forwarded rt; `ex_store_data` = forwarded rt always.
- `aluOp` = registered alu_op. Register 0 is never forwarded.

## Timing
- Latency: `id_*` sampled at edge N appear on `aluOp/op1/op2` after edge N.
- Forward paths are combinational; same-cycle changes on `exmem_*`/`memwb_*` affect `op1/op2` within the cycle.
- Reset values: all `ex_*` 0, `aluOp` 0. `op1`/`op2`/`ex_store_data` = 0 unless a forward source matches.
- `flush` together with `stall_out`: flush wins, bubble inserted, `stall_out` still asserted that cycle.
- `hold` together with `flush`: flush wins.
- `rst` mid-stall: next cycle bubble, `stall_out` 0 (ex_valid 0).

## Structure
- Shared package `mips_pkg`:
  - ALU opcode constants `ALU_ADD`=0, `ALU_SUB`=1, `ALU_OR`=2, `ALU_XOR`=3, `ALU_AND`=4, `ALU_SLTU`=5, `ALU_SLT`=6, `ALU_ADDI`=7.
  - `REG_ZERO`.
- One sub-module: `fwd_mux` (index, regfile data, two forward sources → selected data), instantiated twice.

## Test plan
- Reset then capture add: rs_data=5, rt_data=7, alu_op=0, no hazards → next cycle op1=5, op2=7, aluOp=0, ex_valid=1.
- Double hit: exmem rd=3 result=0xAA, memwb rd=3 result=0xBB, ex rs=3 → op1=0xAA. Drop exmem_reg_write → op1=0xBB.
- rd=0 guard: exmem_rd=0, exmem_reg_write=1, rs=0, rs_data=0 → op1=0.
- Load-use: ex holds lw rd=4, id add rs=4 → stall_out=1; next cycle ex_valid=0, ex_reg_write=0; IF/ID held, following cycle add captured with memwb forward.
- Flush + hold: flush=1, hold=1 with valid id → ex_valid=0 next cycle. Hold alone keeps all ex_* unchanged for 3 cycles.
- Store forwarding: sw with alu_src=1, imm=8, rt=2, exmem_rd=2 result=0x55 → op2=8, ex_store_data=0x55.
